axi4_lite_read_master: RTL and testbench

//  AXI4-Lite read-channel master: converts single core load requests into AR/R

---
 rtl/axi4_lite_read_master_if.sv | 33 +++
 rtl/axi4_lite_read_master.sv | 172 +++++++++++++++++
 tb/tb_axi4_lite_read_master.sv | 304 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/axi4_lite_read_master_if.sv
// AXI4-Lite read address and read data channels shared by a read master and its slave.
interface axi4_lite_read_master_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic [ADDR_WIDTH-1:0] M_AXI_ARADDR;
  logic                  M_AXI_ARVALID;
  logic                  M_AXI_ARREADY;
  logic [DATA_WIDTH-1:0] M_AXI_RDATA;
  logic [1:0]            M_AXI_RRESP;
  logic                  M_AXI_RVALID;
  logic                  M_AXI_RREADY;

  modport master (
    output M_AXI_ARADDR,
    output M_AXI_ARVALID,
    input  M_AXI_ARREADY,
    input  M_AXI_RDATA,
    input  M_AXI_RRESP,
    input  M_AXI_RVALID,
    output M_AXI_RREADY
  );

  modport slave (
    input  M_AXI_ARADDR,
    input  M_AXI_ARVALID,
    output M_AXI_ARREADY,
    output M_AXI_RDATA,
    output M_AXI_RRESP,
    output M_AXI_RVALID,
    input  M_AXI_RREADY
  );
endinterface

// File: rtl/axi4_lite_read_master.sv
// AXI4-Lite read master: turns single core loads into one AR/R transaction at a time.
// Optional watchdog enabled by defining AXI_RD_TIMEOUT_EN.
module axi4_lite_read_master #(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  output logic                  req_ready,
  output logic                  stall,
  output logic                  resp_valid,
  output logic [DATA_WIDTH-1:0] resp_data,
  output logic                  resp_err,
  axi4_lite_read_master_if.master axi
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ADDR = 2'd1,
    ST_DATA = 2'd2,
    ST_RESP = 2'd3
  } state_t;

  state_t                state_r;
  state_t                state_nxt_s;
  logic [ADDR_WIDTH-1:0] addr_r;
  logic [DATA_WIDTH-1:0] data_r;
  logic                  err_r;
  logic                  req_ready_r;
  logic                  stall_r;
  logic                  resp_valid_r;
  logic                  arvalid_r;
  logic                  rready_r;
  logic                  accept_s;
  logic                  capture_s;
  logic                  timeout_s;
  logic                  timeout_fire_s;
  logic                  unused_rresp_s;

  assign accept_s       = (state_r == ST_IDLE) && req_valid;
  assign unused_rresp_s = axi.M_AXI_RRESP[0];

`ifdef AXI_RD_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  logic [CNT_W-1:0] cnt_r;

  // Watchdog counter: cleared when a request is accepted, advances every ADDR/DATA cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_r <= '0;
    end else if (accept_s) begin
      cnt_r <= '0;
    end else if ((state_r == ST_ADDR) || (state_r == ST_DATA)) begin
      cnt_r <= cnt_r + CNT_ONE;
    end else begin
      cnt_r <= cnt_r;
    end
  end

  assign timeout_s = ((state_r == ST_ADDR) || (state_r == ST_DATA)) && (cnt_r == CNT_LIMIT);
`else
  logic [31:0] unused_timeout_s;

  assign unused_timeout_s = 32'(TIMEOUT_CYCLES);
  assign timeout_s        = 1'b0;
`endif

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state decode; a handshake in the limit cycle takes priority over the watchdog
  always_comb begin
    state_nxt_s    = state_r;
    capture_s      = 1'b0;
    timeout_fire_s = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (req_valid) begin
          state_nxt_s = ST_ADDR;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_ADDR: begin
        if (axi.M_AXI_ARREADY) begin
          state_nxt_s = ST_DATA;
        end else if (timeout_s) begin
          state_nxt_s    = ST_RESP;
          timeout_fire_s = 1'b1;
        end else begin
          state_nxt_s = ST_ADDR;
        end
      end
      ST_DATA: begin
        if (axi.M_AXI_RVALID) begin
          state_nxt_s = ST_RESP;
          capture_s   = 1'b1;
        end else if (timeout_s) begin
          state_nxt_s    = ST_RESP;
          timeout_fire_s = 1'b1;
        end else begin
          state_nxt_s = ST_DATA;
        end
      end
      ST_RESP: begin
        state_nxt_s = ST_IDLE;
      end
      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase
  end

  // Address, data and error holding registers
  always_ff @(posedge clk) begin
    if (rst) begin
      addr_r <= '0;
      data_r <= '0;
      err_r  <= 1'b0;
    end else begin
      if (accept_s) begin
        addr_r <= req_addr;
      end
      if (capture_s) begin
        data_r <= axi.M_AXI_RDATA;
        err_r  <= axi.M_AXI_RRESP[1];
      end else if (timeout_fire_s) begin
        data_r <= '0;
        err_r  <= 1'b1;
      end
    end
  end

  // Control outputs registered from the next state so they change only on clock edges
  always_ff @(posedge clk) begin
    if (rst) begin
      req_ready_r  <= 1'b1;
      stall_r      <= 1'b0;
      resp_valid_r <= 1'b0;
      arvalid_r    <= 1'b0;
      rready_r     <= 1'b0;
    end else begin
      req_ready_r  <= (state_nxt_s == ST_IDLE);
      stall_r      <= (state_nxt_s == ST_ADDR) || (state_nxt_s == ST_DATA);
      resp_valid_r <= (state_nxt_s == ST_RESP);
      arvalid_r    <= (state_nxt_s == ST_ADDR);
      rready_r     <= (state_nxt_s == ST_DATA);
    end
  end

  assign req_ready         = req_ready_r;
  assign stall             = stall_r;
  assign resp_valid        = resp_valid_r;
  assign resp_data         = data_r;
  assign resp_err          = err_r;
  assign axi.M_AXI_ARADDR  = addr_r;
  assign axi.M_AXI_ARVALID = arvalid_r;
  assign axi.M_AXI_RREADY  = rready_r;

endmodule

// File: tb/tb_axi4_lite_read_master.sv
// Bench for axi4_lite_read_master: table of reads against a delay-programmable slave
// model, scoreboard of expected responses, plus reset, back-to-back and watchdog sequences.
module tb_axi4_lite_read_master;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int TO = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          req_valid = 1'b0;
  logic [AW-1:0] req_addr = '0;
  logic          req_ready;
  logic          stall;
  logic          resp_valid;
  logic [DW-1:0] resp_data;
  logic          resp_err;

  axi4_lite_read_master_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) axi ();

  axi4_lite_read_master #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_addr(req_addr), .req_ready(req_ready),
    .stall(stall), .resp_valid(resp_valid), .resp_data(resp_data),
    .resp_err(resp_err), .axi(axi)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    int          ar_d;
    int          r_d;
    logic [31:0] exp_data;
    logic        exp_err;
  } vec_t;

  typedef struct {
    logic [31:0] data;
    logic        err;
    int          due;
  } exp_t;

  exp_t        sb_q[$];
  logic [31:0] ar_q[$];
  int          resp_cyc_q[$];
  int          vectors = 0;
  int          miscompares = 0;
  int          cyc = 0;
  int          ar_hs = 0;
  int          arv_cycles = 0;
  logic [31:0] cur_addr = '0;

  int          sl_phase = 0;
  int          sl_cnt = 0;
  int          sl_ar_d = 0;
  int          sl_r_d = 0;
  bit          sl_r_never = 1'b0;
  logic [31:0] sl_rdata = '0;
  logic [1:0]  sl_rresp = 2'b00;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic fail_event(input string name);
    vectors++;
    miscompares++;
    $display("FAIL %s: event occurred, expected none (cycle %0d)", name, cyc);
  endtask

  // Slave model: decides ARREADY/RVALID for the coming edge; a handshake seen here completes at that edge.
  task automatic slave_step();
    axi.M_AXI_ARREADY = 1'b0;
    axi.M_AXI_RVALID  = 1'b0;
    axi.M_AXI_RDATA   = 32'hDEAD_BEEF;
    axi.M_AXI_RRESP   = 2'b11;
    if (rst) begin
      sl_phase = 0;
      sl_cnt   = 0;
    end else if (sl_phase == 0) begin
      if (axi.M_AXI_ARVALID) begin
        if (sl_cnt >= sl_ar_d) begin
          axi.M_AXI_ARREADY = 1'b1;
          ar_hs++;
          if (ar_q.size() == 0) fail_event("ar_unexpected");
          else check("ar_addr", axi.M_AXI_ARADDR, ar_q.pop_front());
          sl_phase = 1;
          sl_cnt   = 0;
        end else begin
          sl_cnt++;
        end
      end
    end else begin
      if (axi.M_AXI_RREADY && !sl_r_never) begin
        if (sl_cnt >= sl_r_d) begin
          axi.M_AXI_RVALID = 1'b1;
          axi.M_AXI_RDATA  = sl_rdata;
          axi.M_AXI_RRESP  = sl_rresp;
          sl_phase = 0;
          sl_cnt   = 0;
        end else begin
          sl_cnt++;
        end
      end
    end
  endtask

  task automatic monitor_step();
    exp_t e;
    if (axi.M_AXI_ARVALID) begin
      arv_cycles++;
      check("araddr_stable", axi.M_AXI_ARADDR, cur_addr);
      check("stall_in_addr", stall, 1'b1);
    end
    if (resp_valid) begin
      resp_cyc_q.push_back(cyc);
      if (sb_q.size() == 0) begin
        fail_event("resp_spurious");
      end else begin
        e = sb_q.pop_front();
        check("resp_data", resp_data, e.data);
        check("resp_err", resp_err, e.err);
        check("resp_cycle", cyc, e.due);
      end
    end
  endtask

  task automatic tick();
    @(negedge clk);
    cyc++;
    slave_step();
    monitor_step();
  endtask

  // Present a request once req_ready is seen; acceptance happens at the next rising edge.
  task automatic issue(input logic [31:0] a, input logic [31:0] d, input logic e, input int lat);
    exp_t x;
    int n = 0;
    while (!req_ready && n < 60) begin
      tick();
      n++;
    end
    if (!req_ready) begin
      fail_event("req_ready_timeout");
    end else begin
      req_valid = 1'b1;
      req_addr  = a;
      cur_addr  = a;
      ar_q.push_back(a);
      x.data = d;
      x.err  = e;
      x.due  = cyc + lat;
      sb_q.push_back(x);
    end
  endtask

  task automatic wait_done();
    int n = 0;
    while (sb_q.size() != 0 && n < 120) begin
      tick();
      n++;
    end
    if (sb_q.size() != 0) begin
      fail_event("resp_timeout");
      sb_q.delete();
      ar_q.delete();
    end
  endtask

  task automatic run_vec(input vec_t v);
    sl_ar_d    = v.ar_d;
    sl_r_d     = v.r_d;
    sl_rdata   = v.rdata;
    sl_rresp   = v.rresp;
    sl_r_never = 1'b0;
    arv_cycles = 0;
    issue(v.addr, v.exp_data, v.exp_err, 3 + v.ar_d + v.r_d);
    tick();
    req_valid = 1'b0;
    wait_done();
    check("arvalid_cycles", arv_cycles, v.ar_d + 1);
    tick();
    tick();
    check("resp_data_hold", resp_data, v.exp_data);
    check("resp_err_hold", resp_err, v.exp_err);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "global timeout");
  end

  initial begin
    vec_t tbl[6];
    int   base;
    int   n;
    tbl[0] = '{32'h0000_1000, 32'hCAFE_F00D, 2'b00, 0, 0, 32'hCAFE_F00D, 1'b0};
    tbl[1] = '{32'h0000_1000, 32'hA5A5_0001, 2'b00, 5, 0, 32'hA5A5_0001, 1'b0};
    tbl[2] = '{32'h0000_2000, 32'h1234_5678, 2'b10, 0, 0, 32'h1234_5678, 1'b1};
    tbl[3] = '{32'h0000_3004, 32'h0BAD_BEEF, 2'b01, 0, 2, 32'h0BAD_BEEF, 1'b0};
    tbl[4] = '{32'hFFFF_FFFC, 32'hFFFF_FFFF, 2'b11, 2, 3, 32'hFFFF_FFFF, 1'b1};
    tbl[5] = '{32'h0000_0000, 32'h0000_0000, 2'b00, 1, 1, 32'h0000_0000, 1'b0};

    axi.M_AXI_ARREADY = 1'b0;
    axi.M_AXI_RVALID  = 1'b0;
    axi.M_AXI_RDATA   = '0;
    axi.M_AXI_RRESP   = 2'b00;

    rst = 1'b1;
    repeat (3) tick();
    check("rst_req_ready", req_ready, 1'b1);
    check("rst_stall", stall, 1'b0);
    check("rst_resp_valid", resp_valid, 1'b0);
    check("rst_resp_data", resp_data, 32'h0);
    check("rst_resp_err", resp_err, 1'b0);
    check("rst_arvalid", axi.M_AXI_ARVALID, 1'b0);
    check("rst_rready", axi.M_AXI_RREADY, 1'b0);
    check("rst_araddr", axi.M_AXI_ARADDR, 32'h0);
    rst = 1'b0;
    tick();

    for (int i = 0; i < 6; i++) begin
      run_vec(tbl[i]);
    end

    // Back-to-back reads with req_valid held high
    sl_ar_d = 0; sl_r_d = 0; sl_rdata = 32'h0BB0_0000; sl_rresp = 2'b00; sl_r_never = 1'b0;
    resp_cyc_q.delete();
    base = ar_hs;
    for (int k = 0; k < 3; k++) begin
      issue(32'(k * 4), 32'h0BB0_0000, 1'b0, 3);
      tick();
    end
    req_valid = 1'b0;
    wait_done();
    check("b2b_ar_handshakes", ar_hs - base, 3);
    check("b2b_resp_count", resp_cyc_q.size(), 3);
    if (resp_cyc_q.size() == 3) begin
      check("b2b_spacing_1", resp_cyc_q[1] - resp_cyc_q[0], 4);
      check("b2b_spacing_2", resp_cyc_q[2] - resp_cyc_q[1], 4);
    end

    // Reset while waiting in DATA abandons the read
    sl_ar_d = 0; sl_r_d = 20; sl_rdata = 32'h7777_7777; sl_rresp = 2'b00;
    issue(32'h0000_4000, 32'h7777_7777, 1'b0, 23);
    tick();
    req_valid = 1'b0;
    n = 0;
    while (!axi.M_AXI_RREADY && n < 20) begin
      tick();
      n++;
    end
    check("rready_before_rst", axi.M_AXI_RREADY, 1'b1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    sb_q.delete();
    ar_q.delete();
    check("midrst_req_ready", req_ready, 1'b1);
    check("midrst_rready", axi.M_AXI_RREADY, 1'b0);
    check("midrst_stall", stall, 1'b0);
    check("midrst_resp_valid", resp_valid, 1'b0);
    check("midrst_resp_data", resp_data, 32'h0);
    base = resp_cyc_q.size();
    repeat (10) tick();
    check("midrst_no_resp", resp_cyc_q.size(), base);
    run_vec(tbl[2]);

`ifdef AXI_RD_TIMEOUT_EN
    // Watchdog in DATA: slave never returns a beat
    sl_ar_d = 0; sl_r_d = 0; sl_r_never = 1'b1;
    issue(32'h0000_6000, 32'h0, 1'b1, 1 + TO);
    tick();
    req_valid = 1'b0;
    wait_done();
    check("to_data_err_hold", resp_err, 1'b1);
    sl_r_never = 1'b0; sl_phase = 0; sl_cnt = 0;
    // Watchdog in ADDR: slave never accepts the address
    sl_ar_d = 1000;
    issue(32'h0000_7000, 32'h0, 1'b1, 1 + TO);
    tick();
    req_valid = 1'b0;
    wait_done();
    tick();
    check("to_addr_arvalid_dropped", axi.M_AXI_ARVALID, 1'b0);
    ar_q.delete();
    sl_phase = 0; sl_cnt = 0;
    run_vec(tbl[0]);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
